config_reg_map: RTL and testbench
=================================

Name: config_reg_map

Overview:
Synchronous register file holding the radar/FMC150 run-time configuration: chirp timing, chirp generator tuning, ADC capture window, FMC150 mode bits and data-path control bits. A command master (host command decoder) writes one 32-bit word per command and receives a one-cycle valid or error response. All configuration outputs drive the chirp generator, FMC150 interface and packet logic directly from flops.

Parameters:
PRF_INT_RST, 32'd1, reset value of ch_prf_int
PRF_FRAC_RST, 32'd0, reset value of ch_prf_frac
TUNING_COEF_RST, 32'd1, reset value of ch_tuning_coef
COUNTER_MAX_RST, 32'h00000FFF, reset value of ch_counter_max
FREQ_OFFSET_RST, 32'd0, reset value of ch_freq_offset
ADC_SAMPLE_TIME_RST, 32'd256, reset value of adc_sample_time

Ports:
clk in 1 sole clock; all logic on posedge
rst in 1 synchronous, active-high reset
wr_cmd in 1 write strobe; one-cycle pulse
wr_addr in 8 register address
wr_data in 32 write data
wr_keep in 32 per-bit write mask; 1 = update bit
wr_valid out 1 one-cycle pulse: write accepted and applied
wr_ready out 1 block can accept wr_cmd
wr_err out 2 error code, valid in the response cycle
ch_prf_int out 32 PRF period, integer part
ch_prf_frac out 32 PRF period, fractional part
ch_tuning_coef out 32 chirp tuning coefficient
ch_counter_max out 32 chirp counter terminal value
ch_freq_offset out 32 chirp frequency offset
adc_sample_time out 32 ADC capture length
ddc_duc_bypass, digital_mode, adc_out_dac_in, external_clock, gen_adc_test_pattern out 1 each, FMC150 mode bits
enable_adc_pkt, gen_tx_data, chk_tx_data out 1 each, packet/data-path control
mac_speed out 2 MAC speed select

Behaviour:
- Address map (write-only):
  - 0x00 ch_prf_int
  - 0x01 ch_prf_frac
  - 0x02 ch_tuning_coef
  - 0x03 ch_counter_max
  - 0x04 ch_freq_offset
  - 0x05 adc_sample_time
  - 0x06 mode: bit0 ddc_duc_bypass, bit1 digital_mode, bit2 adc_out_dac_in, bit3 external_clock, bit4 gen_adc_test_pattern
  - 0x07 control: bit0 enable_adc_pkt, bit1 gen_tx_data, bit2 chk_tx_data, bits4:3 mac_speed
  - 0x08-0xFF unmapped. Unused bits of 0x06/0x07 are ignored.
- Reset, while rst=1 on a clock edge:
  - 32-bit registers load their parameter defaults.
  - Mode bits = 0; enable_adc_pkt = 1; gen_tx_data = 0; chk_tx_data = 0; mac_speed = 2'b10.
  - wr_valid = 0, wr_err = 0, wr_ready = 1.
  - Commands are ignored during reset.
- Accept: a command is accepted on an edge where wr_cmd=1, wr_ready=1 and rst=0. wr_cmd while wr_ready=0 is dropped with no response.
- Response, exactly 1 cycle after accept (registered):
  - wr_valid=1 with wr_err=00 on success; otherwise wr_valid=0 with a nonzero wr_err.
  - Both signals last one cycle; wr_err returns to 00 afterwards.
  - wr_ready=0 during the response cycle and returns to 1 the next cycle. Back-to-back accepts are therefore at most every 2 cycles.
- Error checks, priority order:
  - 11 = address unmapped.
  - 10 = wr_keep[0]=0 (mask not LSB-aligned; includes keep=0).
  - 01 = wr_keep not a contiguous low mask, i.e. (keep & (keep+1)) != 0.
  - No register changes on error.
- Success: new_reg = (old & ~keep) | (wr_data & keep), truncated to the register's implemented bits. The output reflects the new value in the same response cycle where wr_valid=1.
- Reset asserted mid-operation: a pending response is cancelled (no wr_valid/wr_err pulse) and all registers return to defaults.

Test Plan:
- Reset, then idle -> ch_prf_int=1, ch_counter_max=0xFFF, adc_sample_time=256, mac_speed=10, enable_adc_pkt=1, wr_ready=1, wr_valid=0.
- wr_cmd addr 0x05, data 0x1234, keep 0xFFFFFFFF -> next cycle wr_valid=1, wr_err=00, wr_ready=0, adc_sample_time=0x1234; wr_ready=1 the following cycle.
- addr 0x00, keep 0xFFFFFFF0 -> wr_err=10, ch_prf_int unchanged. Retry with keep 0xFFFFFFF1 -> wr_err=01. Retry with keep 0xFFFFFFFF -> wr_valid=1.
- addr 0x08 and addr 0xFF (keep all ones) -> wr_err=11, no output changes. Addr 0x20 with keep 0 -> wr_err=11 (address priority over mask error).
- addr 0x07, data 0x1E, keep 0x1F -> enable_adc_pkt=0, gen_tx_data=1, chk_tx_data=1, mac_speed=11. Then addr 0x02, data 0xABCD, keep 0xFF -> ch_tuning_coef=0x000000CD (upper bits keep reset value 0).
- wr_cmd held high continuously -> exactly one response every 2 cycles. Assert rst in a response-pending cycle -> no response pulse, all defaults restored.

Source files
------------

// File: rtl/config_reg_map.sv
// Run-time configuration register file for the radar chirp generator, FMC150 and packet path.
// Masked single-word writes with a registered one-cycle valid/error response.
module config_reg_map #(
   parameter logic [31:0] PRF_INT_RST         = 32'd1,
   parameter logic [31:0] PRF_FRAC_RST        = 32'd0,
   parameter logic [31:0] TUNING_COEF_RST     = 32'd1,
   parameter logic [31:0] COUNTER_MAX_RST     = 32'h00000FFF,
   parameter logic [31:0] FREQ_OFFSET_RST     = 32'd0,
   parameter logic [31:0] ADC_SAMPLE_TIME_RST = 32'd256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_cmd,
   input  logic [7:0]  wr_addr,
   input  logic [31:0] wr_data,
   input  logic [31:0] wr_keep,
   output logic        wr_valid,
   output logic        wr_ready,
   output logic [1:0]  wr_err,
   output logic [31:0] ch_prf_int,
   output logic [31:0] ch_prf_frac,
   output logic [31:0] ch_tuning_coef,
   output logic [31:0] ch_counter_max,
   output logic [31:0] ch_freq_offset,
   output logic [31:0] adc_sample_time,
   output logic        ddc_duc_bypass,
   output logic        digital_mode,
   output logic        adc_out_dac_in,
   output logic        external_clock,
   output logic        gen_adc_test_pattern,
   output logic        enable_adc_pkt,
   output logic        gen_tx_data,
   output logic        chk_tx_data,
   output logic [1:0]  mac_speed
);

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_CONTIG   = 2'b01;
   localparam logic [1:0] ERR_LSB      = 2'b10;
   localparam logic [1:0] ERR_UNMAPPED = 2'b11;

   localparam logic [4:0] MODE_RST = 5'b00000;
   localparam logic [4:0] CTRL_RST = 5'b10001;

   // Handshake: a command is taken on a posedge with wr_cmd & wr_ready & !rst.
   // The following cycle carries exactly one response (wr_valid or nonzero
   // wr_err) with wr_ready low; commands offered while wr_ready is low are dropped.
   logic        accept;
   logic [1:0]  err_code;
   logic [31:0] keep_inc;

   logic [4:0]  mode_q;
   logic [4:0]  ctrl_q;

   assign accept   = wr_cmd && wr_ready && !rst;
   assign keep_inc = wr_keep + 32'd1;

   always_comb begin
      err_code = ERR_NONE;
      if (wr_addr > 8'h07)
         err_code = ERR_UNMAPPED;
      else if (!wr_keep[0])
         err_code = ERR_LSB;
      else if ((wr_keep & keep_inc) != 32'd0)
         err_code = ERR_CONTIG;
   end

   function automatic logic [31:0] merge32(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [31:0] keep);
      return (old_v & ~keep) | (new_v & keep);
   endfunction

   function automatic logic [4:0] merge5(input logic [4:0] old_v,
                                         input logic [31:0] new_v,
                                         input logic [31:0] keep);
      return (old_v & ~keep[4:0]) | (new_v[4:0] & keep[4:0]);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_valid <= 1'b0;
         wr_err   <= ERR_NONE;
         wr_ready <= 1'b1;
      end else begin
         wr_valid <= accept && (err_code == ERR_NONE);
         wr_err   <= accept ? err_code : ERR_NONE;
         wr_ready <= !accept;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ch_prf_int      <= PRF_INT_RST;
         ch_prf_frac     <= PRF_FRAC_RST;
         ch_tuning_coef  <= TUNING_COEF_RST;
         ch_counter_max  <= COUNTER_MAX_RST;
         ch_freq_offset  <= FREQ_OFFSET_RST;
         adc_sample_time <= ADC_SAMPLE_TIME_RST;
         mode_q          <= MODE_RST;
         ctrl_q          <= CTRL_RST;
      end else if (accept && (err_code == ERR_NONE)) begin
         case (wr_addr[2:0])
            3'd0: ch_prf_int      <= merge32(ch_prf_int, wr_data, wr_keep);
            3'd1: ch_prf_frac     <= merge32(ch_prf_frac, wr_data, wr_keep);
            3'd2: ch_tuning_coef  <= merge32(ch_tuning_coef, wr_data, wr_keep);
            3'd3: ch_counter_max  <= merge32(ch_counter_max, wr_data, wr_keep);
            3'd4: ch_freq_offset  <= merge32(ch_freq_offset, wr_data, wr_keep);
            3'd5: adc_sample_time <= merge32(adc_sample_time, wr_data, wr_keep);
            3'd6: mode_q          <= merge5(mode_q, wr_data, wr_keep);
            default: ctrl_q       <= merge5(ctrl_q, wr_data, wr_keep);
         endcase
      end
   end

   assign ddc_duc_bypass       = mode_q[0];
   assign digital_mode         = mode_q[1];
   assign adc_out_dac_in       = mode_q[2];
   assign external_clock       = mode_q[3];
   assign gen_adc_test_pattern = mode_q[4];

   assign enable_adc_pkt = ctrl_q[0];
   assign gen_tx_data    = ctrl_q[1];
   assign chk_tx_data    = ctrl_q[2];
   assign mac_speed      = ctrl_q[4:3];

endmodule

// File: tb/tb_config_reg_map.sv
// Directed bench for config_reg_map: masked writes, error priority, throughput, reset cancel.
module tb_config_reg_map;

   logic        clk;
   logic        rst;
   logic        wr_cmd;
   logic [7:0]  wr_addr;
   logic [31:0] wr_data;
   logic [31:0] wr_keep;
   logic        wr_valid;
   logic        wr_ready;
   logic [1:0]  wr_err;
   logic [31:0] ch_prf_int;
   logic [31:0] ch_prf_frac;
   logic [31:0] ch_tuning_coef;
   logic [31:0] ch_counter_max;
   logic [31:0] ch_freq_offset;
   logic [31:0] adc_sample_time;
   logic        ddc_duc_bypass;
   logic        digital_mode;
   logic        adc_out_dac_in;
   logic        external_clock;
   logic        gen_adc_test_pattern;
   logic        enable_adc_pkt;
   logic        gen_tx_data;
   logic        chk_tx_data;
   logic [1:0]  mac_speed;

   int checks;
   int failures;

   config_reg_map dut (
      .clk                  (clk),
      .rst                  (rst),
      .wr_cmd               (wr_cmd),
      .wr_addr              (wr_addr),
      .wr_data              (wr_data),
      .wr_keep              (wr_keep),
      .wr_valid             (wr_valid),
      .wr_ready             (wr_ready),
      .wr_err               (wr_err),
      .ch_prf_int           (ch_prf_int),
      .ch_prf_frac          (ch_prf_frac),
      .ch_tuning_coef       (ch_tuning_coef),
      .ch_counter_max       (ch_counter_max),
      .ch_freq_offset       (ch_freq_offset),
      .adc_sample_time      (adc_sample_time),
      .ddc_duc_bypass       (ddc_duc_bypass),
      .digital_mode         (digital_mode),
      .adc_out_dac_in       (adc_out_dac_in),
      .external_clock       (external_clock),
      .gen_adc_test_pattern (gen_adc_test_pattern),
      .enable_adc_pkt       (enable_adc_pkt),
      .gen_tx_data          (gen_tx_data),
      .chk_tx_data          (chk_tx_data),
      .mac_speed            (mac_speed)
   );

   // clock: inputs change and outputs are sampled on the falling edge
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] mode_bits();
      return {gen_adc_test_pattern, external_clock, adc_out_dac_in, digital_mode, ddc_duc_bypass};
   endfunction

   function automatic logic [4:0] ctrl_bits();
      return {mac_speed, chk_tx_data, gen_tx_data, enable_adc_pkt};
   endfunction

   // Offer one command for one edge; returns at the falling edge of the response cycle.
   task automatic send(input logic [7:0] a, input logic [31:0] d, input logic [31:0] k);
      wr_cmd  = 1'b1;
      wr_addr = a;
      wr_data = d;
      wr_keep = k;
      @(negedge clk);
      wr_cmd  = 1'b0;
   endtask

   // Checks the response cycle, then the idle cycle that follows it.
   task automatic check_resp(input string tag, input logic exp_valid, input logic [1:0] exp_err);
      chk({tag, "_valid"}, 32'(wr_valid), 32'(exp_valid));
      chk({tag, "_err"},   32'(wr_err),   32'(exp_err));
      chk({tag, "_ready"}, 32'(wr_ready), 32'd0);
      @(negedge clk);
      chk({tag, "_valid_after"}, 32'(wr_valid), 32'd0);
      chk({tag, "_err_after"},   32'(wr_err),   32'd0);
      chk({tag, "_ready_after"}, 32'(wr_ready), 32'd1);
   endtask

   task automatic check_defaults(input string tag);
      chk({tag, "_prf_int"},     ch_prf_int,      32'd1);
      chk({tag, "_prf_frac"},    ch_prf_frac,     32'd0);
      chk({tag, "_tuning"},      ch_tuning_coef,  32'd1);
      chk({tag, "_counter_max"}, ch_counter_max,  32'h00000FFF);
      chk({tag, "_freq_offset"}, ch_freq_offset,  32'd0);
      chk({tag, "_sample_time"}, adc_sample_time, 32'd256);
      chk({tag, "_mode"},        32'(mode_bits()), 32'h00);
      chk({tag, "_ctrl"},        32'(ctrl_bits()), 32'h11);
      chk({tag, "_ready"},       32'(wr_ready),   32'd1);
      chk({tag, "_valid"},       32'(wr_valid),   32'd0);
      chk({tag, "_err"},         32'(wr_err),     32'd0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      wr_cmd   = 1'b0;
      wr_addr  = 8'h00;
      wr_data  = 32'h0;
      wr_keep  = 32'h0;

      // reset and idle
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_defaults("reset");

      // full-word write
      send(8'h05, 32'h00001234, 32'hFFFFFFFF);
      chk("w05_data", adc_sample_time, 32'h00001234);
      check_resp("w05", 1'b1, 2'b00);

      // mask errors, then a good retry
      send(8'h00, 32'h00000005, 32'hFFFFFFF0);
      check_resp("lsb_err", 1'b0, 2'b10);
      chk("lsb_err_nochg", ch_prf_int, 32'd1);
      send(8'h00, 32'h00000005, 32'hFFFFFFF1);
      check_resp("contig_err", 1'b0, 2'b01);
      chk("contig_err_nochg", ch_prf_int, 32'd1);
      send(8'h00, 32'h00000005, 32'hFFFFFFFF);
      chk("w00_data", ch_prf_int, 32'd5);
      check_resp("w00", 1'b1, 2'b00);

      // unmapped addresses, including address priority over a zero mask
      send(8'h08, 32'hDEADBEEF, 32'hFFFFFFFF);
      check_resp("addr08", 1'b0, 2'b11);
      send(8'hFF, 32'hDEADBEEF, 32'hFFFFFFFF);
      check_resp("addrFF", 1'b0, 2'b11);
      send(8'h20, 32'hDEADBEEF, 32'h00000000);
      check_resp("addr20", 1'b0, 2'b11);
      chk("unmapped_prf_int", ch_prf_int, 32'd5);
      chk("unmapped_sample",  adc_sample_time, 32'h00001234);
      chk("unmapped_ctrl",    32'(ctrl_bits()), 32'h11);

      // control and mode bits, partial masks on 32-bit registers
      send(8'h07, 32'h0000001E, 32'h0000001F);
      chk("ctrl_bits", 32'(ctrl_bits()), 32'h1E);
      check_resp("w07", 1'b1, 2'b00);
      send(8'h02, 32'h0000ABCD, 32'h000000FF);
      chk("tuning_partial", ch_tuning_coef, 32'h000000CD);
      check_resp("w02", 1'b1, 2'b00);
      send(8'h06, 32'hFFFFFF15, 32'h00000007);
      chk("mode_partial", 32'(mode_bits()), 32'h05);
      check_resp("w06", 1'b1, 2'b00);
      send(8'h03, 32'h00000000, 32'h0000000F);
      chk("counter_partial", ch_counter_max, 32'h00000FF0);
      check_resp("w03", 1'b1, 2'b00);

      // wr_cmd held high: one response every other cycle
      wr_cmd  = 1'b1;
      wr_addr = 8'h01;
      wr_data = 32'h00000007;
      wr_keep = 32'hFFFFFFFF;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("held_valid", 32'(wr_valid), (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("held_ready", 32'(wr_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      end
      wr_cmd = 1'b0;
      chk("held_prf_frac", ch_prf_frac, 32'd7);

      // reset during a response cycle restores every default
      send(8'h04, 32'h00000099, 32'hFFFFFFFF);
      chk("pre_rst_valid", 32'(wr_valid), 32'd1);
      chk("pre_rst_freq", ch_freq_offset, 32'h00000099);
      rst = 1'b1;
      @(negedge clk);
      check_defaults("rst_mid");

      // command offered during reset is ignored
      send(8'h05, 32'h00005555, 32'hFFFFFFFF);
      chk("rst_cmd_valid", 32'(wr_valid), 32'd0);
      chk("rst_cmd_err", 32'(wr_err), 32'd0);
      chk("rst_cmd_sample", adc_sample_time, 32'd256);
      rst = 1'b0;
      @(negedge clk);
      check_defaults("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
